// File: rtl/layer_sequencer.sv
// layer_sequencer: tracks input/output VecFIFO fill levels and sequences one layer pass per vector.
// Ports: clk_in/rst_in (async active-low); in_wr_en/in_full producer side; layer_data_ready,
// layer_req_chunk_in/out, layer_out_vector_valid layer side; out_rd_en/out_vec_ready consumer side;
// busy, done, vec_count, err={timeout,protocol,overflow} status.
module layer_sequencer #(
  parameter int InVecLength     = 8,
  parameter int WorkingRegs     = 4,
  parameter int InBytesPerWrite = 1,
  parameter int Depth           = 2,
  parameter int TimeoutCycles   = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        in_wr_en,
  output logic        in_full,
  output logic        layer_data_ready,
  input  logic        layer_req_chunk_in,
  input  logic        layer_req_chunk_out,
  input  logic        layer_out_vector_valid,
  input  logic        out_rd_en,
  output logic        out_vec_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_count,
  output logic [2:0]  err
);
  localparam int Chunks = InVecLength / WorkingRegs;
  localparam int Cap    = Depth * InVecLength;
  localparam int LW     = $clog2(Cap + 1);
  localparam int OW     = $clog2(Depth * Chunks + 1) + 1;
  localparam int CW     = $clog2(Chunks + 2);
  localparam int WW     = $clog2(TimeoutCycles + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERR = 2'd3;
  logic [1:0]    state, state_n;
  logic [LW-1:0] in_level;
  logic [OW-1:0] out_chunks;
  logic [CW-1:0] cin, cout, cin_n, cout_n;
  logic [WW-1:0] wdog;
  logic          vvalid_seen, vv_n;
  logic          run, wr_ok, pop_ok, rd_ok, push_ok, ovf, proto, tmo, start, fin, chunk_ev;
  assign in_full          = in_level > LW'(Cap - InBytesPerWrite);
  assign out_vec_ready    = out_chunks >= OW'(Chunks);
  assign layer_data_ready = state == RUN;
  assign busy             = state != IDLE;
  assign done             = state == DONE;
  always_comb begin
    run      = state == RUN;
    chunk_ev = layer_req_chunk_in || layer_req_chunk_out;
    wr_ok    = in_wr_en && !in_full;
    pop_ok   = layer_req_chunk_in && in_level >= LW'(WorkingRegs);
    rd_ok    = out_rd_en && out_chunks != '0;
    push_ok  = layer_req_chunk_out && out_chunks != '1;
    ovf      = (in_wr_en && in_full) || (out_rd_en && out_chunks == '0);
    cin_n    = cin + CW'(layer_req_chunk_in);
    cout_n   = cout + CW'(layer_req_chunk_out);
    vv_n     = vvalid_seen || layer_out_vector_valid;
    proto    = (!run && chunk_ev) || (run && (cin_n > CW'(Chunks) || cout_n > CW'(Chunks)))
            || (layer_req_chunk_in && in_level < LW'(WorkingRegs));
    tmo      = run && !chunk_ev && wdog == WW'(TimeoutCycles - 1);
    start    = in_level >= LW'(InVecLength) && out_chunks <= OW'((Depth - 1) * Chunks);
    fin      = cin_n == CW'(Chunks) && cout_n == CW'(Chunks) && vv_n;
    state_n  = (proto || tmo)   ? ERR :
               (state == IDLE)  ? (start ? RUN : IDLE) :
               run              ? (fin ? DONE : RUN) :
               (state == DONE)  ? IDLE : ERR;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      in_level    <= '0;
      out_chunks  <= '0;
      cin         <= '0;
      cout        <= '0;
      vvalid_seen <= 1'b0;
      wdog        <= '0;
      vec_count   <= '0;
      err         <= '0;
    end else begin
      state      <= state_n;
      in_level   <= in_level + (wr_ok ? LW'(InBytesPerWrite) : LW'(0)) - (pop_ok ? LW'(WorkingRegs) : LW'(0));
      out_chunks <= out_chunks + OW'(push_ok) - OW'(rd_ok);
      err        <= err | {tmo, proto, ovf};
      // Holding the per-vector counters at zero in IDLE clears them on entry to RUN.
      if (state == IDLE) begin
        cin         <= '0;
        cout        <= '0;
        vvalid_seen <= 1'b0;
        wdog        <= '0;
      end else if (run) begin
        cin         <= cin_n;
        cout        <= cout_n;
        vvalid_seen <= vv_n;
        wdog        <= chunk_ev ? WW'(0) : wdog + WW'(1);
      end
      if (state == DONE) vec_count <= vec_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed self-checking bench for layer_sequencer.
module tb_layer_sequencer;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        in_wr_en = 1'b0, layer_req_chunk_in = 1'b0, layer_req_chunk_out = 1'b0;
  logic        layer_out_vector_valid = 1'b0, out_rd_en = 1'b0;
  logic        in_full, layer_data_ready, out_vec_ready, busy, done;
  logic [15:0] vec_count;
  logic [2:0]  err;
  int          n_cmp = 0, n_bad = 0, dseen;
  layer_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_wr_en(in_wr_en), .in_full(in_full),
    .layer_data_ready(layer_data_ready), .layer_req_chunk_in(layer_req_chunk_in),
    .layer_req_chunk_out(layer_req_chunk_out), .layer_out_vector_valid(layer_out_vector_valid),
    .out_rd_en(out_rd_en), .out_vec_ready(out_vec_ready), .busy(busy), .done(done),
    .vec_count(vec_count), .err(err)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic w, input logic ci, input logic co, input logic vv, input logic rd);
    in_wr_en = w;
    layer_req_chunk_in = ci;
    layer_req_chunk_out = co;
    layer_out_vector_valid = vv;
    out_rd_en = rd;
    @(posedge clk_in);
    #1;
    in_wr_en = 0;
    layer_req_chunk_in = 0;
    layer_req_chunk_out = 0;
    layer_out_vector_valid = 0;
    out_rd_en = 0;
  endtask
  task automatic writes(input int n);
    repeat (n) step(1, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_in = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1;
  endtask
  task automatic vector_pass();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
  endtask
  initial begin
    #1;
    chk("reset_outputs", {in_full, layer_data_ready, out_vec_ready, busy, done, vec_count, err}, 0);
    do_reset();
    // nominal
    writes(8);
    chk("nom_no_start_yet", layer_data_ready, 0);
    step(0, 0, 0, 0, 0);
    chk("nom_ready_rises", layer_data_ready, 1);
    vector_pass();
    chk("nom_done_pulse", done, 1);
    step(0, 0, 0, 0, 0);
    chk("nom_done_single", done, 0);
    chk("nom_vec_count", vec_count, 1);
    chk("nom_out_vec_ready", out_vec_ready, 1);
    chk("nom_idle", busy, 0);
    // output full
    writes(8);
    step(0, 0, 0, 0, 0);
    chk("of_second_run", layer_data_ready, 1);
    vector_pass();
    step(0, 0, 0, 0, 0);
    chk("of_vec_count", vec_count, 2);
    chk("of_out_chunks4", dut.out_chunks, 4);
    writes(8);
    step(0, 0, 0, 0, 0);
    chk("of_blocked", busy, 0);
    step(0, 0, 0, 0, 1);
    chk("of_out_chunks3", dut.out_chunks, 3);
    step(0, 0, 0, 0, 0);
    chk("of_still_blocked", busy, 0);
    step(0, 0, 0, 0, 1);
    chk("of_not_yet", layer_data_ready, 0);
    step(0, 0, 0, 0, 0);
    chk("of_start", layer_data_ready, 1);
    chk("of_err_clean", err, 0);
    // backpressure
    do_reset();
    writes(15);
    chk("bp_not_full15", in_full, 0);
    writes(1);
    chk("bp_full16", in_full, 1);
    writes(1);
    chk("bp_err_ovf", err, 3'b001);
    chk("bp_level_held", dut.in_level, 16);
    chk("bp_state_kept", layer_data_ready, 1);
    // simultaneous events
    do_reset();
    writes(8);
    step(0, 0, 0, 0, 0);
    chk("sim_run", layer_data_ready, 1);
    step(1, 1, 0, 0, 0);
    chk("sim_in_level5", dut.in_level, 5);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("sim_out1", dut.out_chunks, 1);
    step(0, 0, 1, 0, 1);
    chk("sim_out_unchanged", dut.out_chunks, 1);
    step(0, 0, 0, 1, 0);
    chk("sim_done", done, 1);
    chk("sim_err_clean", err, 0);
    // timeout
    do_reset();
    writes(8);
    step(0, 0, 0, 0, 0);
    repeat (63) step(0, 0, 0, 0, 0);
    chk("to_not_yet", {layer_data_ready, err}, {1'b1, 3'b000});
    step(0, 0, 0, 0, 0);
    chk("to_err", err, 3'b100);
    chk("to_state_err", dut.state, 3);
    chk("to_ready_low", layer_data_ready, 0);
    rst_in = 0;
    #1;
    chk("to_async_reset", {in_full, layer_data_ready, out_vec_ready, busy, done, vec_count, err}, 0);
    chk("to_levels_clear", {dut.in_level, dut.out_chunks}, 0);
    // protocol error and mid-run reset
    do_reset();
    step(0, 0, 1, 0, 0);
    chk("pr_err", err, 3'b010);
    chk("pr_state_err", dut.state, 3);
    do_reset();
    writes(8);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pr_midrun", layer_data_ready, 1);
    dseen = 0;
    rst_in = 0;
    repeat (2) begin
      @(posedge clk_in);
      #1;
      dseen += int'(done);
    end
    rst_in = 1;
    repeat (4) begin
      step(0, 0, 0, 0, 0);
      dseen += int'(done);
    end
    chk("pr_no_done", dseen, 0);
    chk("pr_vec_count0", vec_count, 0);
    chk("pr_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
